// File: rtl/ascon_obi_mgr_arb_if.sv
// OBI request/response types and the bundled bus seen by the ASCON manager arbiter.
package ascon_obi_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
  } obi_a_t;

  typedef struct packed {
    logic   req;
    obi_a_t a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        rid;
    logic        err;
  } obi_r_t;

  typedef struct packed {
    logic   gnt;
    logic   rvalid;
    obi_r_t r;
  } mgr_obi_rsp_t;
endpackage

interface ascon_obi_mgr_arb_if #(
  parameter int NumMgr = 5
);
  import ascon_obi_pkg::*;

  mgr_obi_req_t [NumMgr-1:0] mgr_req_i;
  mgr_obi_rsp_t [NumMgr-1:0] mgr_rsp_o;
  mgr_obi_req_t              out_req_o;
  mgr_obi_rsp_t              out_rsp_i;
  logic                      busy_o;
  logic                      err_o;

  modport slave (
    input  mgr_req_i, out_rsp_i,
    output mgr_rsp_o, out_req_o, busy_o, err_o
  );

  modport master (
    output mgr_req_i, out_rsp_i,
    input  mgr_rsp_o, out_req_o, busy_o, err_o
  );
endinterface

// File: rtl/ascon_obi_mgr_arb.sv
// Round-robin merge of the ASCON DMA OBI managers onto one crossbar port,
// with an in-order index FIFO that steers each response back to its issuer.
module ascon_obi_mgr_arb
  import ascon_obi_pkg::*;
#(
  parameter int NumMgr         = 5,
  parameter int MaxOutstanding = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  ascon_obi_mgr_arb_if.slave bus
);
  localparam int IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] r_ptr, r_lock_idx;
  logic            r_lock, r_err;
  logic [IdxW-1:0] r_fifo [MaxOutstanding];
  logic [PtrW-1:0] r_wr, r_rd;
  logic [CntW-1:0] r_cnt;

  logic [IdxW-1:0] w_sel, w_head;
  logic            w_sel_vld, w_req, w_full, w_empty, w_hs, w_pop;

  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NumMgr) s = s - NumMgr;
    return IdxW'(s);
  endfunction

  function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
    return (int'(p) == MaxOutstanding - 1) ? '0 : p + 1'b1;
  endfunction

  // Reverse scan so the lowest offset from r_ptr is the last (winning) assignment.
  always_comb begin
    w_sel     = r_lock_idx;
    w_sel_vld = 1'b0;
    if (r_lock) begin
      w_sel_vld = bus.mgr_req_i[r_lock_idx].req;
    end else begin
      for (int o = NumMgr - 1; o >= 0; o--) begin
        if (bus.mgr_req_i[rr_idx(r_ptr, o)].req) begin
          w_sel     = rr_idx(r_ptr, o);
          w_sel_vld = 1'b1;
        end
      end
    end
  end

  assign w_full  = (r_cnt == CntW'(MaxOutstanding));
  assign w_empty = (r_cnt == '0);
  assign w_req   = w_sel_vld & ~w_full;
  assign w_hs    = w_req & bus.out_rsp_i.gnt;
  assign w_pop   = bus.out_rsp_i.rvalid & ~w_empty;
  assign w_head  = r_fifo[r_rd];

  always_comb begin
    bus.out_req_o     = '0;
    bus.out_req_o.req = w_req;
    if (w_sel_vld) bus.out_req_o.a = bus.mgr_req_i[w_sel].a;
  end

  always_comb begin
    for (int i = 0; i < NumMgr; i++) begin
      bus.mgr_rsp_o[i]        = '0;
      bus.mgr_rsp_o[i].r      = bus.out_rsp_i.r;
      bus.mgr_rsp_o[i].gnt    = w_hs & (w_sel == IdxW'(i));
      bus.mgr_rsp_o[i].rvalid = w_pop & (w_head == IdxW'(i));
    end
  end

  assign bus.busy_o = ~w_empty;
  assign bus.err_o  = r_err;

  // A stalled request stays pinned to its manager; a stall caused by a full
  // FIFO leaves the lock as it was.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_hs) begin
      r_ptr  <= rr_idx(w_sel, 1);
      r_lock <= 1'b0;
    end else if (w_req) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_sel;
    end else if (r_lock && !w_full && !w_sel_vld) begin
      r_lock <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_hs) r_fifo[r_wr] <= w_sel;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_hs)  r_wr <= inc_ptr(r_wr);
      if (w_pop) r_rd <= inc_ptr(r_rd);
      case ({w_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (bus.out_rsp_i.rvalid && w_empty) r_err <= 1'b1;
    end
  end
endmodule
